// File: rtl/axis_pp_pkg.sv
// Shared types and constants for the AXI-Stream ping-pong demultiplexer.
//   pp_state_e : controller FSM state (IDLE, ACTIVE)
//   MODE_*     : packet framing selection
//   pp_clog2   : index width helper, never returns less than 1
package axis_pp_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pp_state_e;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_TLAST = 1'b1;

    function automatic int unsigned pp_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pp_ctrl.sv
// Packet/group controller for axis_pingpong_demux.
// Tracks beat and packet counters, shadow configuration, the current output
// channel (path), the sticky framing error flag and the IDLE/ACTIVE FSM.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   i_accept                 : input beat handshake this cycle
//   i_last                   : input TLAST of the offered beat
//   i_mode/i_pkt_size/i_pp_group : live configuration (latched at group start)
//   i_hold_valid, i_drain    : output holding register state for the FSM
//   o_path                   : channel receiving the next accepted beat
//   o_end                    : offered beat ends its packet (output TLAST)
//   o_pkt_err                : sticky count/TLAST disagreement flag
module axis_pp_ctrl
    import axis_pp_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 32,
    localparam int unsigned PW = pp_clog2(NCH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_accept,
    input  logic          i_last,
    input  logic          i_mode,
    input  logic [CW-1:0] i_pkt_size,
    input  logic [CW-1:0] i_pp_group,
    input  logic          i_hold_valid,
    input  logic          i_drain,
    output logic [PW-1:0] o_path,
    output logic          o_end,
    output logic          o_pkt_err
);

    logic [CW-1:0] r_beat_cnt, r_grp_cnt, r_pkt, r_grp;
    logic          r_mode;
    logic [PW-1:0] r_path;
    logic          r_pkt_err;
    pp_state_e     r_state, w_state_nxt;

    logic          w_grp_start, w_mode, w_cnt_end, w_grp_end;
    logic [CW-1:0] w_pkt, w_grp;

    // At group start the live configuration applies to the beat being
    // accepted, so it is used directly and captured into the shadows.
    always_comb begin
        w_grp_start = (r_beat_cnt == '0) && (r_grp_cnt == '0);
        w_mode      = r_mode;
        w_pkt       = r_pkt;
        w_grp       = r_grp;
        if (w_grp_start) begin
            w_mode = i_mode;
            w_pkt  = (i_pkt_size == '0) ? CW'(1) : i_pkt_size;
            w_grp  = (i_pp_group == '0) ? CW'(1) : i_pp_group;
        end
        w_cnt_end = (r_beat_cnt == w_pkt - CW'(1));
        w_grp_end = (r_grp_cnt == w_grp - CW'(1));
        o_end     = (w_mode == MODE_TLAST) ? i_last : w_cnt_end;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_accept) w_state_nxt = ACTIVE;
            ACTIVE:  if (!i_accept && w_grp_start && (!i_hold_valid || i_drain)) begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_beat_cnt <= '0;
            r_grp_cnt  <= '0;
            r_pkt      <= '0;
            r_grp      <= '0;
            r_mode     <= MODE_COUNT;
            r_path     <= '0;
            r_pkt_err  <= 1'b0;
            r_state    <= IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (i_accept) begin
                if (w_grp_start) begin
                    r_mode <= w_mode;
                    r_pkt  <= w_pkt;
                    r_grp  <= w_grp;
                end
                if ((w_mode == MODE_COUNT) && (i_last != w_cnt_end)) begin
                    r_pkt_err <= 1'b1;
                end
                if (o_end) begin
                    r_beat_cnt <= '0;
                    if (w_grp_end) begin
                        r_grp_cnt <= '0;
                        r_path    <= (r_path == PW'(NCH - 1)) ? '0 : r_path + PW'(1);
                    end else begin
                        r_grp_cnt <= r_grp_cnt + CW'(1);
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + CW'(1);
                end
            end
        end
    end

    assign o_path    = r_path;
    assign o_pkt_err = r_pkt_err;

endmodule

// File: rtl/axis_pingpong_demux.sv
// AXI-Stream round-robin packet distributor over NCH output channels,
// switching channel every PP_GROUP packets, with one registered output stage.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   MODE                 : 0 = count framing, 1 = TLAST framing
//   PACKET_SIZE/PP_GROUP : beats per packet / packets per channel (0 -> 1)
//   S_AXIS_*             : input stream
//   M_AXIS_*             : NCH output streams, channel i in slice i
//   path                 : channel receiving the next accepted beat
//   pkt_err              : sticky framing disagreement (MODE 0)
module axis_pingpong_demux
    import axis_pp_pkg::*;
#(
    parameter int unsigned DW  = 512,
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 32,
    localparam int unsigned PW = pp_clog2(NCH),
    localparam int unsigned KW = DW / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              MODE,
    input  logic [CW-1:0]     PACKET_SIZE,
    input  logic [CW-1:0]     PP_GROUP,
    input  logic [DW-1:0]     S_AXIS_TDATA,
    input  logic [KW-1:0]     S_AXIS_TKEEP,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    output logic [NCH*DW-1:0] M_AXIS_TDATA,
    output logic [NCH*KW-1:0] M_AXIS_TKEEP,
    output logic [NCH-1:0]    M_AXIS_TLAST,
    output logic [NCH-1:0]    M_AXIS_TVALID,
    input  logic [NCH-1:0]    M_AXIS_TREADY,
    output logic [PW-1:0]     path,
    output logic              pkt_err
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;
    logic          r_last;
    logic [PW-1:0] r_ch;

    logic w_accept, w_drain, w_end;

    assign w_drain       = r_valid & M_AXIS_TREADY[r_ch];
    assign S_AXIS_TREADY = resetn & (~r_valid | M_AXIS_TREADY[r_ch]);
    assign w_accept      = S_AXIS_TVALID & S_AXIS_TREADY;

    axis_pp_ctrl #(
        .NCH (NCH),
        .CW  (CW)
    ) u_ctrl (
        .clk          (clk),
        .resetn       (resetn),
        .i_accept     (w_accept),
        .i_last       (S_AXIS_TLAST),
        .i_mode       (MODE),
        .i_pkt_size   (PACKET_SIZE),
        .i_pp_group   (PP_GROUP),
        .i_hold_valid (r_valid),
        .i_drain      (w_drain),
        .o_path       (path),
        .o_end        (w_end),
        .o_pkt_err    (pkt_err)
    );

    // Reload takes priority over drain so back-to-back beats have no bubble.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_ch    <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= S_AXIS_TDATA;
            r_keep  <= S_AXIS_TKEEP;
            r_last  <= w_end;
            r_ch    <= path;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Unselected channels present all-zero payload.
    always_comb begin
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = '0;
        M_AXIS_TVALID = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_valid && (r_ch == PW'(i))) begin
                M_AXIS_TDATA[i*DW +: DW] = r_data;
                M_AXIS_TKEEP[i*KW +: KW] = r_keep;
                M_AXIS_TLAST[i]          = r_last;
                M_AXIS_TVALID[i]         = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pingpong_demux.sv
module tb_axis_pingpong_demux;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int KW  = DW / 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cfg_mode = 1'b0;
    logic [CW-1:0]     cfg_pkt = '0;
    logic [CW-1:0]     cfg_grp = '0;
    logic [DW-1:0]     s_tdata = '0;
    logic [KW-1:0]     s_tkeep = '0;
    logic              s_tlast = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [NCH*DW-1:0] m_tdata;
    logic [NCH*KW-1:0] m_tkeep;
    logic [NCH-1:0]    m_tlast;
    logic [NCH-1:0]    m_tvalid;
    logic [NCH-1:0]    m_tready = '1;
    logic [1:0]        path;
    logic              pkt_err;

    always #5 clk = ~clk;

    axis_pingpong_demux #(
        .DW  (DW),
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .MODE          (cfg_mode),
        .PACKET_SIZE   (cfg_pkt),
        .PP_GROUP      (cfg_grp),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TKEEP  (s_tkeep),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TKEEP  (m_tkeep),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .path          (path),
        .pkt_err       (pkt_err)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    // Reference model: beats in flight plus framing position.
    beat_t q[$];
    int    m_beat, m_pk, m_path;
    bit    m_err;
    bit    sh_mode;
    int    sh_pkt, sh_grp;

    // What the DUT actually delivered, in order.
    int            log_ch[$];
    logic          log_last[$];
    logic [DW-1:0] log_data[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit last_acc;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_accept();
        beat_t b;
        bit    e;
        if (m_beat == 0 && m_pk == 0) begin
            sh_mode = cfg_mode;
            sh_pkt  = (cfg_pkt == 0) ? 1 : int'(cfg_pkt);
            sh_grp  = (cfg_grp == 0) ? 1 : int'(cfg_grp);
        end
        e = sh_mode ? s_tlast : (m_beat == sh_pkt - 1);
        if (!sh_mode && (s_tlast != e)) m_err = 1'b1;
        b.ch = m_path; b.data = s_tdata; b.keep = s_tkeep; b.last = e;
        q.push_back(b);
        if (e) begin
            m_beat = 0;
            if (m_pk == sh_grp - 1) begin
                m_pk   = 0;
                m_path = (m_path + 1) % NCH;
            end else begin
                m_pk++;
            end
        end else begin
            m_beat++;
        end
    endtask

    // One clock: pre-edge ready check and handshake prediction, edge, then
    // post-edge comparison of every output against the model.
    task automatic tick();
        bit                er, acc, drn;
        int                oc;
        logic [NCH*DW-1:0] ed;
        logic [NCH*KW-1:0] ek;
        logic [NCH-1:0]    ev, el;
        if (rnd_ready) m_tready = NCH'($urandom);
        #1;
        er = resetn && (q.size() == 0 || m_tready[q[0].ch]);
        chk("s_tready", s_tready, er);
        acc = s_tvalid && er;
        drn = resetn && q.size() != 0 && m_tready[q[0].ch];
        last_acc = acc;
        if (drn) begin
            oc = -1;
            for (int c = 0; c < NCH; c++) if (m_tvalid[c]) oc = c;
            log_ch.push_back(oc);
            log_last.push_back(oc >= 0 ? m_tlast[oc] : 1'b0);
            log_data.push_back(oc >= 0 ? m_tdata[oc*DW +: DW] : '0);
        end
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            q.delete();
            m_beat = 0; m_pk = 0; m_path = 0; m_err = 1'b0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) model_accept();
        end
        @(negedge clk);
        ev = '0; ed = '0; ek = '0; el = '0;
        if (q.size() != 0) begin
            ev[q[0].ch]          = 1'b1;
            el[q[0].ch]          = q[0].last;
            ed[q[0].ch*DW +: DW] = q[0].data;
            ek[q[0].ch*KW +: KW] = q[0].keep;
        end
        chk("m_tvalid", m_tvalid, ev);
        chk("m_tdata", m_tdata, ed);
        chk("m_tkeep", m_tkeep, ek);
        chk("m_tlast", m_tlast, el);
        chk("path", path, m_path);
        chk("pkt_err", pkt_err, m_err);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input bit rnd_v);
        int n = 0;
        s_tdata = d;
        s_tlast = l;
        s_tkeep = KW'($urandom);
        do begin
            s_tvalid = rnd_v ? 1'($urandom) : 1'b1;
            tick();
            n++;
        end while (!last_acc && n < 300);
        if (!last_acc) chk("send_timeout", 1, 0);
        s_tvalid = 1'b0;
    endtask

    task automatic flush();
        s_tvalid = 1'b0;
        m_tready = '1;
        repeat (4) tick();
    endtask

    task automatic clear_log();
        log_ch.delete();
        log_last.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        rnd_ready = 1'b0;
        m_tready = '1;
        tick();
        tick();
        resetn = 1'b1;
        clear_log();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[4];
        int c0, k;
        bit el;
        @(negedge clk);

        // 1: count framing, 4-beat packets, groups of 2, sinks always ready
        do_reset();
        chk("reset_path", path, 0);
        chk("reset_err", pkt_err, 0);
        chk("reset_valid", m_tvalid, 0);
        cfg_mode = 1'b0; cfg_pkt = 4; cfg_grp = 2;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(DW'(i), (i % 4) == 3, 1'b0);
        chk("t1_no_bubble", cyc - c0, 16);
        flush();
        chk("t1_count", log_ch.size(), 16);
        for (int i = 0; i < 16 && i < log_ch.size(); i++) begin
            chk("t1_ch", log_ch[i], i / 8);
            chk("t1_last", log_last[i], (i % 4) == 3);
            chk("t1_data", log_data[i], i);
        end
        chk("t1_path", path, 2);

        // 2: TLAST framing, one packet per channel, path wraps
        do_reset();
        cfg_mode = 1'b1; cfg_pkt = 0; cfg_grp = 1;
        lens = '{1, 3, 2, 5};
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < lens[p]; b++) send(DW'(p * 16 + b), b == lens[p] - 1, 1'b0);
        flush();
        chk("t2_count", log_ch.size(), 11);
        k = 0;
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < lens[p]; b++) begin
                if (k < log_ch.size()) begin
                    chk("t2_ch", log_ch[k], p);
                    chk("t2_last", log_last[k], b == lens[p] - 1);
                end
                k++;
            end
        chk("t2_path_wrap", path, 0);
        chk("t2_err", pkt_err, 0);

        // 3: random source valid and sink ready against the model
        do_reset();
        cfg_mode = 1'b0; cfg_pkt = 4; cfg_grp = 3;
        rnd_ready = 1'b1;
        for (int i = 0; i < 48; i++) send(DW'($urandom), (i % 4) == 3, 1'b1);
        rnd_ready = 1'b0;
        flush();
        chk("t3_count", log_ch.size(), 48);
        for (int i = 0; i < log_ch.size(); i++) chk("t3_ch", log_ch[i], i / 12);

        // 4: early input TLAST in count mode sets a sticky error
        do_reset();
        cfg_mode = 1'b0; cfg_pkt = 3; cfg_grp = 1;
        send(DW'(100), 1'b0, 1'b0);
        send(DW'(101), 1'b1, 1'b0);
        send(DW'(102), 1'b0, 1'b0);
        flush();
        chk("t4_err_set", pkt_err, 1);
        for (int i = 0; i < 3 && i < log_last.size(); i++) chk("t4_last", log_last[i], i == 2);
        for (int i = 0; i < 3; i++) send(DW'(200 + i), i == 2, 1'b0);
        flush();
        chk("t4_err_sticky", pkt_err, 1);

        // 5: packet size change mid-group applies from the next group
        do_reset();
        cfg_mode = 1'b0; cfg_pkt = 4; cfg_grp = 2;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) cfg_pkt = 2;
            el = (i < 8) ? ((i % 4) == 3) : ((i % 2) == 1);
            send(DW'(i), el, 1'b0);
        end
        flush();
        chk("t5_count", log_ch.size(), 12);
        for (int i = 0; i < 12 && i < log_ch.size(); i++) begin
            chk("t5_ch", log_ch[i], i < 8 ? 0 : 1);
            chk("t5_last", log_last[i], (i < 8) ? ((i % 4) == 3) : ((i % 2) == 1));
        end
        chk("t5_err", pkt_err, 0);

        // 6: reset mid-packet with a beat held in the output register
        do_reset();
        cfg_mode = 1'b0; cfg_pkt = 4; cfg_grp = 1;
        send(DW'(1), 1'b0, 1'b0);
        send(DW'(2), 1'b0, 1'b0);
        flush();
        m_tready = '0;
        send(DW'(3), 1'b0, 1'b0);
        chk("t6_held", m_tvalid, 4'b0001);
        resetn = 1'b0;
        tick();
        chk("t6_rst_valid", m_tvalid, 0);
        chk("t6_rst_data", m_tdata, 0);
        chk("t6_rst_path", path, 0);
        resetn = 1'b1;
        m_tready = '1;
        clear_log();
        for (int i = 0; i < 4; i++) send(DW'(50 + i), i == 3, 1'b0);
        flush();
        chk("t6_count", log_ch.size(), 4);
        for (int i = 0; i < 4 && i < log_ch.size(); i++) begin
            chk("t6_ch", log_ch[i], 0);
            chk("t6_last", log_last[i], i == 3);
            chk("t6_data", log_data[i], 50 + i);
        end
        chk("t6_err", pkt_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_pingpong_demux.md
# axis_pingpong_demux

Parametrised AXI-Stream packet distributor that steers an input stream round-robin across NCH output channels, switching channel after every PP_GROUP packets. It generalises the two-way ping-pong splitter with full backpressure, a registered output stage, TKEEP/TLAST propagation and selectable packet framing. It sits between the capture DMA front end and the per-channel frame buffers.

## Interface
- DW, 512, data width in bits (multiple of 8)
- NCH, 2, number of output channels (2..8)
- CW, 32, width of size/count configuration and counters
- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- MODE  in  1  0 = count framing (PACKET_SIZE beats), 1 = TLAST framing (input TLAST ends packet)
- PACKET_SIZE  in  CW  beats per packet in MODE 0; 0 treated as 1
- PP_GROUP  in  CW  packets per channel before switching; 0 treated as 1
- S_AXIS_TDATA / TKEEP / TLAST / TVALID  in  DW / DW/8 / 1 / 1  input stream
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA  out  NCH*DW  channel i at [i*DW +: DW]
- M_AXIS_TKEEP  out  NCH*DW/8  channel i at [i*DW/8 +: DW/8]
- M_AXIS_TLAST / TVALID  out  NCH  one bit per channel
- M_AXIS_TREADY  in  NCH  one bit per channel
- path  out  clog2(NCH)  channel that receives the next accepted beat
- pkt_err  out  1  sticky: MODE 0 and input TLAST disagreed with counted boundary

## Operation
- Accept = S_AXIS_TVALID & S_AXIS_TREADY. All counters advance only on accept; stalls never lose or duplicate beats.
- Output stage: one holding register (data, keep, last, channel index, valid). On accept, register loads the beat tagged with current path.
- Only M_AXIS_TVALID[ch_reg] may be high; other channels' TVALID = 0, their TDATA/TKEEP/TLAST = 0.
- Packet end: MODE 0 when beat_cnt == PKT-1 (PKT = max(PACKET_SIZE,1)); MODE 1 when input TLAST = 1. Output TLAST = 1 on that beat only.
- On packet end: beat_cnt <= 0; if grp_cnt == GRP-1 then grp_cnt <= 0 and path <= (path == NCH-1) ? 0 : path+1, else grp_cnt++.
- MODE 0: input TLAST = 1 on a non-end beat, or 0 on an end beat, sets pkt_err; framing follows the counter. pkt_err clears only on reset.
- MODE, PACKET_SIZE, PP_GROUP latched into shadow registers on accept when beat_cnt == 0 and grp_cnt == 0 (group start); mid-group changes take effect at next group start.
- FSM: IDLE (counters at group start, no beat held) -> ACTIVE on first accept; ACTIVE -> IDLE when a group completes and the holding register drains with no new accept that cycle; otherwise stay ACTIVE.

## Timing
- Latency: beat accepted in cycle n is presented on M_AXIS in cycle n+1.
- S_AXIS_TREADY = resetn & (~valid_reg | M_AXIS_TREADY[ch_reg]); full throughput of one beat/cycle when the selected sink is ready, including across channel switches.
- Once M_AXIS_TVALID is high, data/keep/last held stable until that channel's TREADY.
- Simultaneous drain and accept: register reloads the same cycle, no bubble.
- Downstream stall on channel A does not allow beats to leak to channel B.
- Reset (any time, including mid-packet): all M_AXIS_TVALID = 0, TDATA/TKEEP/TLAST = 0, S_AXIS_TREADY = 0, path = 0, counters = 0, pkt_err = 0, FSM = IDLE; held beat discarded.

## Structure
- Package axis_pp_pkg: FSM state typedef (IDLE, ACTIVE), MODE constants (MODE_COUNT = 0, MODE_TLAST = 1), clog2 helper.
- One sub-module natural: axis_pp_ctrl (counters, shadow config, path, pkt_err, FSM); top holds output register and channel fan-out.

## Test plan
- NCH=2, MODE 0, PACKET_SIZE=4, PP_GROUP=2, 16 beats, sinks always ready -> beats 0-7 on ch0, 8-15 on ch1, TLAST on beats 3,7,11,15, no bubbles.
- NCH=4, MODE 1, PP_GROUP=1, packets of 1,3,2,5 beats -> one packet per channel 0,1,2,3, path wraps to 0, TLAST mirrors input.
- MODE 0, sink ch0 TREADY toggled randomly, source TVALID random -> scoreboard exact order and data, no beat on ch1 during ch0 group.
- MODE 0, PACKET_SIZE=3, input TLAST on beat 1 -> pkt_err = 1, output TLAST still on beat 2, stays 1 until reset.
- PACKET_SIZE changed 4->2 mid-group -> current group keeps 4-beat packets, next group uses 2.
- resetn low mid-packet with beat held -> next cycle all TVALID = 0, path = 0; after release, first packet starts on ch0 with beat_cnt 0.
